adder_operand_sequencer: RTL and testbench
==========================================

# adder_operand_sequencer

Sequential front/back end for the 2-bit adder stage: captures two operands from the board switches on successive load-button presses and drives them into the adder. It then registers the adder's 2-bit sum and holds it with a valid flag for a fixed display window. It wraps the combinational adder, feeding its `a`/`b` inputs and consuming its `out`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 8: number of cycles `result_valid` stays high after a sum is captured; legal range ≥1.
- `CNT_W`, default 4: hold-counter width; must satisfy 2^CNT_W ≥ HOLD_CYCLES.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous active-high reset.
- `sw`, in, 2: operand value from switches.
- `load`, in, 1: load button, level; only rising edges act.
- `clear`, in, 1: synchronous abort/clear, level-sensitive.
- `op_a`, out, 2: registered operand A, to adder `a`.
- `op_b`, out, 2: registered operand B, to adder `b`.
- `sum_in`, in, 2: adder output `out` (combinational from `op_a`/`op_b`).
- `result`, out, 2: registered sum.
- `result_valid`, out, 1: high while `result` is being presented.
- `state`, out, 2: current FSM state, for LEDs.

## Operation
- Edge detect: `load_q <= load` every cycle; `load_rise = load & ~load_q`.
- FSM states: S_A=0 (await A), S_B=1 (await B), S_SUM=2, S_SHOW=3.
- S_A: on `load_rise`, `op_a <= sw` and go to S_B.
- S_B: on `load_rise`, `op_b <= sw` and go to S_SUM.
- S_SUM: lasts one cycle, unconditionally. `result <= sum_in`, `result_valid <= 1`, `cnt <= HOLD_CYCLES-1`, go to S_SHOW. A `load_rise` in this cycle is dropped.
- S_SHOW, with priority `load_rise` over count:
  - On `load_rise`: `op_a <= sw`, `result_valid <= 0`, go to S_B. This chains the next operation.
  - Else if `cnt==0`: `result_valid <= 0`, go to S_A.
  - Else: `cnt <= cnt-1`.
- `result` keeps its last value after `result_valid` drops. `op_a`/`op_b` hold until overwritten.
- Arithmetic: the sum is 2-bit modulo-4, with the carry discarded, exactly as the adder delivers it. This block does no arithmetic of its own.
- `clear` (priority below `rst`, above everything else): state goes to S_A; `op_a`, `op_b`, `result`, `result_valid` and `cnt` all go to 0. `load_q` still samples `load`.
- `rst`: same as `clear`, plus `load_q <= 1`. A button held through reset therefore does not produce an edge; it must be released and pressed again.

## Timing
- Reset values: `op_a=0`, `op_b=0`, `result=0`, `result_valid=0`, `state=S_A`, `cnt=0`, `load_q=1`.
- Capture latency: if `load` is first sampled high at edge k, the operand register updates at edge k.
- Sum latency: if the B press is sampled at edge k, `result` and `result_valid=1` appear after edge k+1.
- `result_valid` is high for exactly HOLD_CYCLES cycles, from edge k+1 to edge k+1+HOLD_CYCLES, unless cut short by `load_rise`, `clear` or `rst`.
- Simultaneous `clear` and `load_rise`: `clear` wins and the edge is consumed.
- A `rst` or `clear` mid-sequence, in any state, aborts without producing a result.

## Structure
- Shared header `adder_seq_defs.vh` holds the state encodings S_A/S_B/S_SUM/S_SHOW and `OPW=2`. The adder stage and the top level use it.
- One sub-module, `rise_detect`: `clk`, `rst`, `in`, `pulse`, with a reset-to-1 history flop. Instantiated once, for `load`.
- The adder is instantiated at the top level, not inside this block.

## Test plan
- Reset with `load` held high, then release and press again. Required: no capture while held through reset; the first capture happens on the new press.
- `sw=2'b01` then press, `sw=2'b10` then press. Required: `op_a=1`, `op_b=2`; at edge k+1 `result=2'b11` with `result_valid=1`; valid stays high for 8 cycles, then state is S_A.
- Operands 3 and 2. Required: `result=2'b01` (wrap-around, carry discarded).
- During S_SHOW, set `sw=2'b11` and press. Required: `result_valid` drops next edge, `op_a=3`, state S_B; `result` keeps its old value.
- Assert `clear` in S_B with `op_a=2`. Required: all outputs 0 and state S_A next edge; a press in the same cycle is ignored.
- Press during the single S_SUM cycle. Required: the press is ignored and `op_a` is unchanged; `HOLD_CYCLES=1` gives exactly one valid cycle.

Source files
------------

// File: rtl/adder_operand_sequencer_pkg.sv
// Shared definitions for the adder operand sequencer: operand width and FSM state encodings.
package adder_operand_sequencer_pkg;

    localparam int OPW = 2;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_SUM  = 2'd2,
        S_SHOW = 2'd3
    } state_t;

endpackage

// File: rtl/adder_operand_sequencer_rise_detect.sv
// Rising-edge detector. The history flop resets to 1, so an input held high through reset
// must be released and asserted again before it produces a pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/adder_operand_sequencer.sv
// Captures two operands from the switches on successive load presses, feeds them to the
// external adder, then registers the sum and presents it with a valid flag for a hold window.
module adder_operand_sequencer
    import adder_operand_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] sw,
    input  logic           load,
    input  logic           clear,
    output logic [OPW-1:0] op_a,
    output logic [OPW-1:0] op_b,
    input  logic [OPW-1:0] sum_in,
    output logic [OPW-1:0] result,
    output logic           result_valid,
    output logic [1:0]     state
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             load_rise;

    rise_detect u_load_rise (
        .clk   (clk),
        .rst   (rst),
        .in    (load),
        .pulse (load_rise)
    );

    // A press while showing a result restarts the sequence with that press as operand A,
    // so the hold window gives way to the press before the counter is considered.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            st           <= S_A;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            cnt          <= '0;
        end else begin
            case (st)
                S_A: begin
                    if (load_rise) begin
                        op_a <= sw;
                        st   <= S_B;
                    end
                end
                S_B: begin
                    if (load_rise) begin
                        op_b <= sw;
                        st   <= S_SUM;
                    end
                end
                S_SUM: begin
                    result       <= sum_in;
                    result_valid <= 1'b1;
                    cnt          <= HOLD_LAST;
                    st           <= S_SHOW;
                end
                S_SHOW: begin
                    if (load_rise) begin
                        op_a         <= sw;
                        result_valid <= 1'b0;
                        st           <= S_B;
                    end else if (cnt == '0) begin
                        result_valid <= 1'b0;
                        st           <= S_A;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: st <= S_A;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed bench for adder_operand_sequencer; a behavioural 2-bit adder closes the loop.
module tb_adder_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst, load, clear;
    logic [1:0] sw;

    logic [1:0] op_a1, op_b1, sum1, result1, state1;
    logic       valid1;
    logic [1:0] op_a2, op_b2, sum2, result2, state2;
    logic       valid2;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign sum1 = 2'(op_a1 + op_b1);
    assign sum2 = 2'(op_a2 + op_b2);

    adder_operand_sequencer #(.HOLD_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .load(load), .clear(clear),
        .op_a(op_a1), .op_b(op_b1), .sum_in(sum1),
        .result(result1), .result_valid(valid1), .state(state1)
    );

    adder_operand_sequencer #(.HOLD_CYCLES(1), .CNT_W(1)) dut_h1 (
        .clk(clk), .rst(rst), .sw(sw), .load(load), .clear(clear),
        .op_a(op_a2), .op_b(op_b2), .sum_in(sum2),
        .result(result2), .result_valid(valid2), .state(state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] v);
        sw   = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; clear = 1'b0; sw = 2'd3;
        tick(); tick();
        checks++;
        if ({op_a1, op_b1, result1, valid1, state1} !== 9'd0)
            $display("[TB] FAIL reset_outputs got %b want 0", {op_a1, op_b1, result1, valid1, state1});
        else passed++;
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (op_a1 !== 2'd0 || state1 !== 2'd0)
            $display("[TB] FAIL held_through_reset op_a=%0d state=%0d want 0/0", op_a1, state1);
        else passed++;
        load = 1'b0;
        tick();
        sw = 2'd1; load = 1'b1;
        tick();
        checks++;
        if (op_a1 !== 2'd1 || state1 !== 2'd1)
            $display("[TB] FAIL new_press op_a=%0d state=%0d want 1/1", op_a1, state1);
        else passed++;
        load = 1'b0;
        tick();
    endtask

    task automatic test_basic_sum();
        clear = 1'b1; tick(); clear = 1'b0;
        press(2'd1);
        sw = 2'd2; load = 1'b1;
        tick();
        checks++;
        if (op_a1 !== 2'd1 || op_b1 !== 2'd2 || state1 !== 2'd2 || valid1 !== 1'b0)
            $display("[TB] FAIL operands op_a=%0d op_b=%0d state=%0d valid=%b want 1/2/2/0",
                     op_a1, op_b1, state1, valid1);
        else passed++;
        load = 1'b0;
        tick();
        checks++;
        if (result1 !== 2'b11 || valid1 !== 1'b1 || state1 !== 2'd3)
            $display("[TB] FAIL sum_1_2 result=%0d valid=%b state=%0d want 3/1/3", result1, valid1, state1);
        else passed++;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (valid1 !== 1'b1)
                $display("[TB] FAIL hold_window cycle %0d valid=%b want 1", i + 2, valid1);
            else passed++;
        end
        tick();
        checks++;
        if (valid1 !== 1'b0 || state1 !== 2'd0 || result1 !== 2'b11)
            $display("[TB] FAIL hold_expiry valid=%b state=%0d result=%0d want 0/0/3", valid1, state1, result1);
        else passed++;
    endtask

    task automatic test_wrap();
        press(2'd3);
        press(2'd2);
        checks++;
        if (result1 !== 2'b01 || valid1 !== 1'b1)
            $display("[TB] FAIL wrap_3_2 result=%0d valid=%b want 1/1", result1, valid1);
        else passed++;
    endtask

    task automatic test_chain();
        tick();
        sw = 2'd3; load = 1'b1;
        tick();
        checks++;
        if (valid1 !== 1'b0 || op_a1 !== 2'd3 || state1 !== 2'd1 || result1 !== 2'b01)
            $display("[TB] FAIL chain valid=%b op_a=%0d state=%0d result=%0d want 0/3/1/1",
                     valid1, op_a1, state1, result1);
        else passed++;
        load = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        press(2'd2);
        checks++;
        if (op_a1 !== 2'd2 || state1 !== 2'd1)
            $display("[TB] FAIL clear_setup op_a=%0d state=%0d want 2/1", op_a1, state1);
        else passed++;
        clear = 1'b1; sw = 2'd1; load = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({op_a1, op_b1, result1, valid1, state1} !== 9'd0)
            $display("[TB] FAIL clear_outputs got %b want 0", {op_a1, op_b1, result1, valid1, state1});
        else passed++;
        tick();
        checks++;
        if (op_a1 !== 2'd0 || state1 !== 2'd0)
            $display("[TB] FAIL clear_edge_consumed op_a=%0d state=%0d want 0/0", op_a1, state1);
        else passed++;
        load = 1'b0;
        tick();
    endtask

    task automatic test_sum_press_hold1();
        clear = 1'b1; tick(); clear = 1'b0;
        press(2'd1);
        sw = 2'd2; load = 1'b1;
        tick();
        sw = 2'd3;
        tick();
        checks++;
        if (op_a1 !== 2'd1 || state1 !== 2'd3 || result1 !== 2'b11)
            $display("[TB] FAIL sum_press op_a=%0d state=%0d result=%0d want 1/3/3", op_a1, state1, result1);
        else passed++;
        checks++;
        if (valid2 !== 1'b1 || result2 !== 2'b11 || op_a2 !== 2'd1)
            $display("[TB] FAIL hold1_valid valid=%b result=%0d op_a=%0d want 1/3/1", valid2, result2, op_a2);
        else passed++;
        load = 1'b0;
        tick();
        checks++;
        if (valid2 !== 1'b0 || state2 !== 2'd0)
            $display("[TB] FAIL hold1_expiry valid=%b state=%0d want 0/0", valid2, state2);
        else passed++;
        checks++;
        if (valid1 !== 1'b1)
            $display("[TB] FAIL hold8_still_valid valid=%b want 1", valid1);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_wrap();
        test_chain();
        test_clear();
        test_sum_press_hold1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
